// File: rtl/pong_pkg.sv
// Shared types and constants for the vPong ball engine.
package pong_pkg;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } state_t;

  localparam int P1_BIT = 0;
  localparam int P2_BIT = 1;

endpackage

// File: rtl/pong_paddle_hit.sv
// Combinational paddle zone test: is the ball column over the paddle, and in which half.
module pong_paddle_hit #(
  parameter int COORD_W = 7,
  parameter int PAD_W   = 6
) (
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] pad_x,
  output logic               in_zone,
  output logic               right_half
);

  localparam int CW1 = COORD_W + 1;

  logic [COORD_W:0] bx;
  logic [COORD_W:0] lo;
  logic [COORD_W:0] hi;
  logic [COORD_W:0] offset;

  // One extra bit keeps pad_x + PAD_W - 1 from wrapping near the right edge.
  always_comb begin
    bx         = {1'b0, ball_x};
    lo         = {1'b0, pad_x};
    hi         = lo + CW1'(PAD_W - 1);
    offset     = bx - lo;
    in_zone    = (bx >= lo) && (bx <= hi);
    right_half = (offset >= CW1'(PAD_W / 2));
  end

endmodule

// File: rtl/pong_ball_engine.sv
// Ball engine for vPong: serve/play/over FSM, paddle and wall reflection, scoring.
// Optional PONG_SPEEDUP_EN: half-rate ball until a rally has enough paddle hits.
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int FIELD_W      = 64,
  parameter int FIELD_H      = 48,
  parameter int COORD_W      = 7,
  parameter int PAD_W        = 6,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_DELAY  = 16,
  parameter int SERVE_X      = 10,
  parameter int SERVE_Y      = 3,
  parameter int HITS_PER_LVL = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_en,
  input  logic               start,
  input  logic [COORD_W-1:0] pad1_x,
  input  logic [COORD_W-1:0] pad2_x,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic               dir_right,
  output logic               dir_down,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         point,
  output logic               game_over
);

  localparam int CNT_W = $clog2(SERVE_DELAY + 1);
  localparam logic [COORD_W-1:0] SX     = COORD_W'(SERVE_X);
  localparam logic [COORD_W-1:0] SY     = COORD_W'(SERVE_Y);
  localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(FIELD_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(FIELD_H - 1);
  localparam logic [COORD_W-1:0] Y_PAD2 = COORD_W'(FIELD_H - 2);
  localparam logic [SCORE_W-1:0] WIN_S  = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   CNT_END = CNT_W'(SERVE_DELAY - 1);

  state_t             state, state_n;
  logic [COORD_W-1:0] ball_x_n, ball_y_n, nx, ny;
  logic               dir_right_n, dir_down_n, dr_t, dd_t;
  logic [SCORE_W-1:0] score1_n, score2_n, s1_inc, s2_inc;
  logic [1:0]         point_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               in1, rh1, in2, rh2;
  logic               hit_top, hit_bot, move;

`ifdef PONG_SPEEDUP_EN
  localparam int HIT_W = $clog2(HITS_PER_LVL + 1);
  localparam logic [HIT_W-1:0] HIT_MAX = HIT_W'(HITS_PER_LVL);
  logic [HIT_W-1:0] hits, hits_n;
  logic             phase, phase_n;
`endif

  pong_paddle_hit #(.COORD_W(COORD_W), .PAD_W(PAD_W)) u_hit1 (
    .ball_x(ball_x), .pad_x(pad1_x), .in_zone(in1), .right_half(rh1)
  );

  pong_paddle_hit #(.COORD_W(COORD_W), .PAD_W(PAD_W)) u_hit2 (
    .ball_x(ball_x), .pad_x(pad2_x), .in_zone(in2), .right_half(rh2)
  );

  assign game_over = (state == OVER);
  assign s1_inc    = (score1 == WIN_S) ? score1 : score1 + 1'b1;
  assign s2_inc    = (score2 == WIN_S) ? score2 : score2 + 1'b1;

  always_comb begin
    state_n     = state;
    ball_x_n    = ball_x;
    ball_y_n    = ball_y;
    dir_right_n = dir_right;
    dir_down_n  = dir_down;
    score1_n    = score1;
    score2_n    = score2;
    point_n     = '0;
    cnt_n       = cnt;
    hit_top     = (ball_y == COORD_W'(1)) && !dir_down && in1;
    hit_bot     = (ball_y == Y_PAD2) && dir_down && in2;
    dr_t        = dir_right;
    dd_t        = dir_down;
`ifdef PONG_SPEEDUP_EN
    hits_n  = hits;
    phase_n = phase;
    move    = (hits == HIT_MAX) || phase;
`else
    move    = 1'b1;
`endif
    if (hit_top) begin
      dd_t = 1'b1;
      dr_t = rh1;
    end
    if (hit_bot) begin
      dd_t = 1'b0;
      dr_t = rh2;
    end
    // Walls are applied last so they override a paddle's x direction.
    if (ball_x == '0)
      dr_t = 1'b1;
    else if (ball_x == X_MAX)
      dr_t = 1'b0;
    nx = dr_t ? ball_x + 1'b1 : ball_x - 1'b1;
    ny = dd_t ? ball_y + 1'b1 : ball_y - 1'b1;

    unique case (state)
      SERVE: begin
        if (step_en) begin
          if (cnt == CNT_END) begin
            state_n = PLAY;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      PLAY: begin
        if (step_en) begin
`ifdef PONG_SPEEDUP_EN
          if (hits != HIT_MAX) phase_n = !phase;
`endif
          if (move) begin
            dir_right_n = dr_t;
            dir_down_n  = dd_t;
`ifdef PONG_SPEEDUP_EN
            if ((hit_top || hit_bot) && hits != HIT_MAX) hits_n = hits + 1'b1;
`endif
            if (ny == Y_LAST || ny == '0) begin
              ball_x_n = SX;
              ball_y_n = SY;
              cnt_n    = '0;
`ifdef PONG_SPEEDUP_EN
              hits_n  = '0;
              phase_n = 1'b0;
`endif
              if (ny == Y_LAST) begin
                score1_n        = s1_inc;
                point_n[P1_BIT] = 1'b1;
                dir_down_n      = 1'b1;
                state_n         = (s1_inc == WIN_S) ? OVER : SERVE;
              end else begin
                score2_n        = s2_inc;
                point_n[P2_BIT] = 1'b1;
                dir_down_n      = 1'b0;
                state_n         = (s2_inc == WIN_S) ? OVER : SERVE;
              end
            end else begin
              ball_x_n = nx;
              ball_y_n = ny;
            end
          end
        end
      end
      OVER: begin
        if (start) begin
          score1_n = '0;
          score2_n = '0;
          cnt_n    = '0;
          state_n  = SERVE;
        end
      end
      default: state_n = SERVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SERVE;
      ball_x    <= SX;
      ball_y    <= SY;
      dir_right <= 1'b1;
      dir_down  <= 1'b1;
      score1    <= '0;
      score2    <= '0;
      point     <= '0;
      cnt       <= '0;
`ifdef PONG_SPEEDUP_EN
      hits      <= '0;
      phase     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      ball_x    <= ball_x_n;
      ball_y    <= ball_y_n;
      dir_right <= dir_right_n;
      dir_down  <= dir_down_n;
      score1    <= score1_n;
      score2    <= score2_n;
      point     <= point_n;
      cnt       <= cnt_n;
`ifdef PONG_SPEEDUP_EN
      hits      <= hits_n;
      phase     <= phase_n;
`endif
    end
  end

endmodule

// File: tb/tb_pong_ball_engine.sv
// Randomised scoreboard bench for pong_ball_engine against a behavioural game model.
module tb_pong_ball_engine;

  localparam int FIELD_W      = 64;
  localparam int FIELD_H      = 48;
  localparam int COORD_W      = 7;
  localparam int PAD_W        = 6;
  localparam int SCORE_W      = 4;
  localparam int WIN_SCORE    = 9;
  localparam int SERVE_DELAY  = 16;
  localparam int SERVE_X      = 10;
  localparam int SERVE_Y      = 3;
  localparam int HITS_PER_LVL = 4;
  localparam int N_CYCLES     = 9000;

  typedef struct packed {
    logic [COORD_W-1:0] bx;
    logic [COORD_W-1:0] by;
    logic               dr;
    logic               dd;
    logic [SCORE_W-1:0] s1;
    logic [SCORE_W-1:0] s2;
    logic [1:0]         pt;
    logic               go;
  } obs_t;

  logic               clk = 1'b0;
  logic               reset, step_en, start;
  logic [COORD_W-1:0] pad1_x, pad2_x;
  logic [COORD_W-1:0] ball_x, ball_y;
  logic               dir_right, dir_down;
  logic [SCORE_W-1:0] score1, score2;
  logic [1:0]         point;
  logic               game_over;

  pong_ball_engine #(
    .FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .COORD_W(COORD_W), .PAD_W(PAD_W),
    .SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE), .SERVE_DELAY(SERVE_DELAY),
    .SERVE_X(SERVE_X), .SERVE_Y(SERVE_Y), .HITS_PER_LVL(HITS_PER_LVL)
  ) dut (
    .clk(clk), .reset(reset), .step_en(step_en), .start(start),
    .pad1_x(pad1_x), .pad2_x(pad2_x), .ball_x(ball_x), .ball_y(ball_y),
    .dir_right(dir_right), .dir_down(dir_down), .score1(score1), .score2(score2),
    .point(point), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Game model: plain integers, the ball as position plus unit velocity.
  int m_x, m_y, m_dx, m_dy, m_s1, m_s2, m_pt, m_wait, m_hits, m_phase;
  bit m_serving, m_over;
  obs_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_overs  = 0;

  task automatic model_serve_after_miss();
    m_x = SERVE_X; m_y = SERVE_Y; m_wait = 0; m_hits = 0; m_phase = 0;
  endtask

  task automatic model_move(input int p1, input int p2);
    int ny;
    if (m_y == 1 && m_dy < 0 && m_x >= p1 && m_x <= p1 + PAD_W - 1) begin
      m_dy = 1;
      m_dx = (m_x - p1 >= PAD_W / 2) ? 1 : -1;
      if (m_hits < HITS_PER_LVL) m_hits++;
    end
    if (m_y == FIELD_H - 2 && m_dy > 0 && m_x >= p2 && m_x <= p2 + PAD_W - 1) begin
      m_dy = -1;
      m_dx = (m_x - p2 >= PAD_W / 2) ? 1 : -1;
      if (m_hits < HITS_PER_LVL) m_hits++;
    end
    if (m_x == 0) m_dx = 1;
    if (m_x == FIELD_W - 1) m_dx = -1;
    ny = m_y + m_dy;
    if (ny == FIELD_H - 1) begin
      if (m_s1 < WIN_SCORE) m_s1++;
      m_pt = 1; m_dy = 1;
      model_serve_after_miss();
      if (m_s1 == WIN_SCORE) begin m_over = 1; m_serving = 0; end else m_serving = 1;
    end else if (ny == 0) begin
      if (m_s2 < WIN_SCORE) m_s2++;
      m_pt = 2; m_dy = -1;
      model_serve_after_miss();
      if (m_s2 == WIN_SCORE) begin m_over = 1; m_serving = 0; end else m_serving = 1;
    end else begin
      m_x = m_x + m_dx;
      m_y = ny;
    end
  endtask

  task automatic model_edge(input bit rst, input bit st, input bit sta, input int p1, input int p2);
    bit go;
    m_pt = 0;
    if (rst) begin
      m_x = SERVE_X; m_y = SERVE_Y; m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0;
      m_wait = 0; m_hits = 0; m_phase = 0; m_serving = 1; m_over = 0;
    end else if (m_over) begin
      if (sta) begin
        m_s1 = 0; m_s2 = 0; m_over = 0; m_serving = 1; m_wait = 0;
      end
    end else if (st) begin
      if (m_serving) begin
        m_wait++;
        if (m_wait == SERVE_DELAY) begin m_serving = 0; m_wait = 0; end
      end else begin
        go = 1;
`ifdef PONG_SPEEDUP_EN
        if (m_hits < HITS_PER_LVL) begin
          go = (m_phase != 0);
          m_phase = 1 - m_phase;
        end
`endif
        if (go) model_move(p1, p2);
      end
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.bx = COORD_W'(m_x);
    o.by = COORD_W'(m_y);
    o.dr = (m_dx > 0);
    o.dd = (m_dy > 0);
    o.s1 = SCORE_W'(m_s1);
    o.s2 = SCORE_W'(m_s2);
    o.pt = 2'(m_pt);
    o.go = m_over;
    return o;
  endfunction

  task automatic drive(input bit rst, input bit st, input bit sta, input int p1, input int p2);
    reset   = rst;
    step_en = st;
    start   = sta;
    pad1_x  = COORD_W'(p1);
    pad2_x  = COORD_W'(p2);
    model_edge(rst, st, sta, p1, p2);
    if (m_over) n_overs++;
    exp_q.push_back(model_obs());
  endtask

  function automatic int pick_pad(input int bx);
    int r, p;
    r = $urandom_range(0, 9);
    if (r < 3) begin
      p = bx - $urandom_range(0, PAD_W - 1);
      if (p < 0) p = 0;
    end else if (r < 8) begin
      p = $urandom_range(0, FIELD_W - 1);
    end else begin
      p = $urandom_range(FIELD_W - PAD_W, (1 << COORD_W) - 1);
    end
    return p;
  endfunction

  // Monitor: every clock the DUT presents a fresh output set; compare it to the oldest expectation.
  initial begin
    obs_t e, g;
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        g = '{bx: ball_x, by: ball_y, dr: dir_right, dd: dir_down,
              s1: score1, s2: score2, pt: point, go: game_over};
        n_checks++;
        if (g === e) n_pass++;
        else
          $display("FAIL outputs cyc=%0d got ball=(%0d,%0d) dr=%0b dd=%0b s=%0d/%0d pt=%b go=%b expected ball=(%0d,%0d) dr=%0b dd=%0b s=%0d/%0d pt=%b go=%b",
                   cyc, g.bx, g.by, g.dr, g.dd, g.s1, g.s2, g.pt, g.go,
                   e.bx, e.by, e.dr, e.dd, e.s1, e.s2, e.pt, e.go);
      end
    end
  end

  initial begin
    bit did_rst, r, sta;
    did_rst = 0;
    reset = 1'b1; step_en = 1'b0; start = 1'b0; pad1_x = '0; pad2_x = '0;
    repeat (2) begin
      @(negedge clk);
      drive(1, 0, 0, 0, 0);
    end
    for (int i = 0; i < N_CYCLES; i++) begin
      @(negedge clk);
      r = 0;
      if (!did_rst && i >= 1500 && !m_serving && !m_over) begin
        r = 1;
        did_rst = 1;
      end
      sta = m_over ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      drive(r, $urandom_range(0, 2) != 0, sta, pick_pad(m_x), pick_pad(m_x));
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain pending=%0d expected 0", exp_q.size());
    n_checks++;
    if (n_overs > 0) n_pass++;
    else $display("FAIL game_over_reached got 0 cycles in OVER expected >0");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
